// File: rtl/random_access_memory.sv
// 16x8 program/data RAM: asynchronous read, posedge write from the CPU bus (run) or front-panel switches (manual).
// A post-reset sequencer zeroes every location one per cycle while busy is high.
module random_access_memory #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read_from_bus,
    input  logic                  write_to_bus,
    input  logic                  manual_mode,
    input  logic                  manual_write,
    input  logic [DATA_WIDTH-1:0] manual_switches,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  out_enable,
    output logic [DATA_WIDTH-1:0] contents,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                  btn_prev_q, btn_prev_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic run_wr;
    logic man_wr;

    assign busy       = (state_q == ST_CLEAR);
    assign contents   = mem_q[address];
    assign bus_out    = mem_q[address];
    assign out_enable = write_to_bus && !manual_mode && !busy && !rst;

    // Rising edge of the button only; btn_prev tracks the button in every mode.
    assign run_wr = !busy && !manual_mode && read_from_bus;
    assign man_wr = !busy && manual_mode && manual_write && !btn_prev_q;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        btn_prev_d = manual_write;
        mem_d      = mem_q;
        if (state_q == ST_CLEAR) begin
            mem_d[clr_ptr_q] = '0;
            clr_ptr_d        = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_ADDR) begin
                state_d = ST_IDLE;
            end
        end else if (run_wr) begin
            mem_d[address] = bus_in;
        end else if (man_wr) begin
            mem_d[address] = manual_switches;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_ptr_q  <= '0;
            btn_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    // Storage has no reset value; the clear sequence supplies the zeroes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

endmodule
